// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 16 x 32 register bank: round-robin between ALU
// writeback and load return, with a load scoreboard that stalls hazards.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_wr_valid,
  input  logic [ADDR_W-1:0]        alu_wr_dest,
  input  logic [DATA_W-1:0]        alu_wr_data,
  output logic                     alu_wr_ready,
  input  logic                     ld_wr_valid,
  input  logic [ADDR_W-1:0]        ld_wr_dest,
  input  logic [DATA_W-1:0]        ld_wr_data,
  output logic                     ld_wr_ready,
  input  logic                     ld_issue_valid,
  input  logic [ADDR_W-1:0]        ld_issue_dest,
  output logic                     ld_issue_ready,
  input  logic [ADDR_W-1:0]        rd_src1,
  input  logic [ADDR_W-1:0]        rd_src2,
  output logic                     rd_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dest,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic                     err
);

  localparam int NREG = 2**ADDR_W;

  logic            prio_r;
  logic            rf_is_ld_r;
  logic            alu_elig_s;
  logic            ld_elig_s;
  logic            alu_gnt_s;
  logic            ld_gnt_s;
  logic            ld_hit_s;
  logic            issue_set_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Eligibility and single-grant round-robin arbitration; readies held low in reset.
  always_comb begin
    alu_elig_s = alu_wr_valid & ~pending[alu_wr_dest];
    ld_elig_s  = ld_wr_valid;
    alu_gnt_s  = 1'b0;
    ld_gnt_s   = 1'b0;
    if (rst_n) begin
      if (alu_elig_s && ld_elig_s) begin
        if (prio_r) begin
          ld_gnt_s = 1'b1;
        end else begin
          alu_gnt_s = 1'b1;
        end
      end else if (alu_elig_s) begin
        alu_gnt_s = 1'b1;
      end else if (ld_elig_s) begin
        ld_gnt_s = 1'b1;
      end else begin
        alu_gnt_s = 1'b0;
      end
    end else begin
      alu_gnt_s = 1'b0;
    end
  end

  assign alu_wr_ready = alu_gnt_s;
  assign ld_wr_ready  = ld_gnt_s;
  assign ld_hit_s     = pending[ld_wr_dest];

  // Scoreboard masks: the clear follows the committed load write, one cycle after its grant.
  always_comb begin
    ld_issue_ready = rst_n & ~pending[ld_issue_dest];
    issue_set_s    = ld_issue_ready & ld_issue_valid;
    set_mask_s     = '0;
    clr_mask_s     = '0;
    if (issue_set_s) begin
      set_mask_s[ld_issue_dest] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (rf_we && rf_is_ld_r) begin
      clr_mask_s[rf_dest] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
  end

  // Read hazard: no bypass, so an in-flight bank write also stalls decode.
  always_comb begin
    rd_stall = pending[rd_src1] | pending[rd_src2] |
               (rf_we & ((rf_dest == rd_src1) | (rf_dest == rd_src2)));
  end

  // Registered bank write port, priority pointer, scoreboard and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_dest    <= '0;
      rf_wdata   <= '0;
      rf_is_ld_r <= 1'b0;
      prio_r     <= 1'b0;
      pending    <= '0;
      err        <= 1'b0;
    end else begin
      if (alu_elig_s && ld_elig_s) begin
        prio_r <= alu_gnt_s;
      end else begin
        prio_r <= prio_r;
      end
      if (alu_gnt_s) begin
        rf_we      <= 1'b1;
        rf_dest    <= alu_wr_dest;
        rf_wdata   <= alu_wr_data;
        rf_is_ld_r <= 1'b0;
      end else if (ld_gnt_s && ld_hit_s) begin
        rf_we      <= 1'b1;
        rf_dest    <= ld_wr_dest;
        rf_wdata   <= ld_wr_data;
        rf_is_ld_r <= 1'b1;
      end else begin
        rf_we      <= 1'b0;
        rf_is_ld_r <= 1'b0;
      end
      // A return to a register with no outstanding load is dropped and flagged.
      err     <= err | (ld_gnt_s & ~ld_hit_s);
      pending <= (pending & ~clr_mask_s) | set_mask_s;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected bank writes are queued at
// stimulus time and a negedge monitor pops and compares every rf_we cycle.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_wr_valid;
  logic [3:0]  alu_wr_dest;
  logic [31:0] alu_wr_data;
  logic        alu_wr_ready;
  logic        ld_wr_valid;
  logic [3:0]  ld_wr_dest;
  logic [31:0] ld_wr_data;
  logic        ld_wr_ready;
  logic        ld_issue_valid;
  logic [3:0]  ld_issue_dest;
  logic        ld_issue_ready;
  logic [3:0]  rd_src1;
  logic [3:0]  rd_src2;
  logic        rd_stall;
  logic        rf_we;
  logic [3:0]  rf_dest;
  logic [31:0] rf_wdata;
  logic [15:0] pending;
  logic        err;

  logic [35:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_valid(alu_wr_valid), .alu_wr_dest(alu_wr_dest),
    .alu_wr_data(alu_wr_data), .alu_wr_ready(alu_wr_ready),
    .ld_wr_valid(ld_wr_valid), .ld_wr_dest(ld_wr_dest),
    .ld_wr_data(ld_wr_data), .ld_wr_ready(ld_wr_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_dest(ld_issue_dest),
    .ld_issue_ready(ld_issue_ready),
    .rd_src1(rd_src1), .rd_src2(rd_src2), .rd_stall(rd_stall),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
    .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bank-write monitor: every rf_we cycle must match the next queued write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {rf_dest, rf_wdata}, 36'h0);
      end else begin
        chk("bank_write", {rf_dest, rf_wdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a;
    int  l;
    bit  exp_alu;
    bit  got;

    rst_n = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_dest = 4'd3; alu_wr_data = 32'h1111_1111;
    ld_wr_valid = 1'b1;  ld_wr_dest = 4'd4;  ld_wr_data = 32'h2222_2222;
    ld_issue_valid = 1'b1; ld_issue_dest = 4'd5;
    rd_src1 = 4'd15; rd_src2 = 4'd14;

    // Reset with every input active
    tick(); tick();
    @(negedge clk);
    chk("rst_rf_we", {35'd0, rf_we}, 36'd0);
    chk("rst_pending", {20'd0, pending}, 36'd0);
    chk("rst_alu_ready", {35'd0, alu_wr_ready}, 36'd0);
    chk("rst_ld_ready", {35'd0, ld_wr_ready}, 36'd0);
    chk("rst_issue_ready", {35'd0, ld_issue_ready}, 36'd0);
    chk("rst_err", {35'd0, err}, 36'd0);
    tick();
    alu_wr_valid = 1'b0; ld_wr_valid = 1'b0; ld_issue_valid = 1'b0;
    rst_n = 1'b1;

    // Lone ALU write
    alu_wr_valid = 1'b1; alu_wr_dest = 4'd3; alu_wr_data = 32'hDEAD_BEEF;
    exp_q.push_back({4'd3, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("lone_alu_ready", {35'd0, alu_wr_ready}, 36'd1);
    tick();
    alu_wr_valid = 1'b0;
    @(negedge clk);
    chk("lone_rf_we", {35'd0, rf_we}, 36'd1);
    chk("lone_rf_dest", {32'd0, rf_dest}, 36'd3);
    tick();
    @(negedge clk);
    chk("lone_rf_we_drop", {35'd0, rf_we}, 36'd0);
    tick();

    // Make r10..r12 pending so the contended load returns are legal
    for (int k = 0; k < 3; k++) begin
      ld_issue_valid = 1'b1; ld_issue_dest = 4'(10 + k);
      tick();
    end
    ld_issue_valid = 1'b0;
    @(negedge clk);
    chk("issue_10_12", {20'd0, pending}, 36'h0_0000_1C00);
    tick();

    // Continuous contention: ALU, load, ALU, load, ALU, load
    a = 0; l = 0;
    for (int i = 0; i < 6; i++) begin
      alu_wr_valid = 1'b1; alu_wr_dest = 4'd1; alu_wr_data = 32'hA000_0000 + 32'(a);
      ld_wr_valid = 1'b1;  ld_wr_dest = 4'(10 + l); ld_wr_data = 32'hB000_0000 + 32'(l);
      exp_alu = ((i % 2) == 0);
      if (exp_alu) exp_q.push_back({4'd1, 32'hA000_0000 + 32'(a)});
      else         exp_q.push_back({4'(10 + l), 32'hB000_0000 + 32'(l)});
      @(negedge clk);
      chk($sformatf("rr_alu_ready_%0d", i), {35'd0, alu_wr_ready}, {35'd0, exp_alu});
      chk($sformatf("rr_ld_ready_%0d", i), {35'd0, ld_wr_ready}, {35'd0, !exp_alu});
      if (i > 0) chk($sformatf("rr_rf_we_%0d", i), {35'd0, rf_we}, 36'd1);
      tick();
      if (exp_alu) a++;
      else l++;
    end
    alu_wr_valid = 1'b0; ld_wr_valid = 1'b0;
    @(negedge clk);
    chk("rr_rf_we_6", {35'd0, rf_we}, 36'd1);
    tick();
    @(negedge clk);
    chk("rr_pending_clear", {20'd0, pending}, 36'd0);
    tick();

    // Scoreboard and read stall on r5
    ld_issue_valid = 1'b1; ld_issue_dest = 4'd5;
    @(negedge clk);
    chk("sb_issue_ready", {35'd0, ld_issue_ready}, 36'd1);
    tick();
    ld_issue_valid = 1'b0;
    rd_src1 = 4'd5;
    @(negedge clk);
    chk("sb_pending_r5", {20'd0, pending}, 36'h0_0000_0020);
    chk("sb_stall_r5", {35'd0, rd_stall}, 36'd1);
    tick();
    ld_wr_valid = 1'b1; ld_wr_dest = 4'd5; ld_wr_data = 32'h5555_AAAA;
    exp_q.push_back({4'd5, 32'h5555_AAAA});
    @(negedge clk);
    chk("sb_ld_ready_N", {35'd0, ld_wr_ready}, 36'd1);
    tick();
    ld_wr_valid = 1'b0;
    @(negedge clk);
    chk("sb_rf_we_N1", {35'd0, rf_we}, 36'd1);
    chk("sb_stall_N1", {35'd0, rd_stall}, 36'd1);
    chk("sb_pending_N1", {20'd0, pending}, 36'h0_0000_0020);
    tick();
    @(negedge clk);
    chk("sb_pending_N2", {20'd0, pending}, 36'd0);
    chk("sb_stall_N2", {35'd0, rd_stall}, 36'd0);
    tick();
    rd_src1 = 4'd15;

    // WAW: ALU write to pending r7 waits for the load return to r7
    ld_issue_valid = 1'b1; ld_issue_dest = 4'd7;
    tick();
    ld_issue_valid = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_dest = 4'd7; alu_wr_data = 32'h7777_0001;
    @(negedge clk);
    chk("waw_pending_r7", {20'd0, pending}, 36'h0_0000_0080);
    chk("waw_alu_blocked", {35'd0, alu_wr_ready}, 36'd0);
    tick();
    ld_wr_valid = 1'b1; ld_wr_dest = 4'd7; ld_wr_data = 32'h7777_0002;
    exp_q.push_back({4'd7, 32'h7777_0002});
    exp_q.push_back({4'd7, 32'h7777_0001});
    @(negedge clk);
    chk("waw_alu_blocked_ldgnt", {35'd0, alu_wr_ready}, 36'd0);
    chk("waw_ld_ready", {35'd0, ld_wr_ready}, 36'd1);
    tick();
    ld_wr_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (alu_wr_ready) got = 1'b1;
      tick();
    end
    chk("waw_alu_granted", {35'd0, got}, 36'd1);
    alu_wr_valid = 1'b0;
    tick();
    tick();

    // Duplicate issue to r2 is refused; issue to r9 is accepted
    ld_issue_valid = 1'b1; ld_issue_dest = 4'd2;
    tick();
    @(negedge clk);
    chk("dup_issue_ready", {35'd0, ld_issue_ready}, 36'd0);
    tick();
    ld_issue_dest = 4'd9;
    @(negedge clk);
    chk("issue_r9_ready", {35'd0, ld_issue_ready}, 36'd1);
    tick();
    ld_issue_valid = 1'b0;
    @(negedge clk);
    chk("dup_pending", {20'd0, pending}, 36'h0_0000_0204);
    tick();

    // Spurious load return to non-pending r4
    ld_wr_valid = 1'b1; ld_wr_dest = 4'd4; ld_wr_data = 32'h4444_4444;
    @(negedge clk);
    chk("spur_ld_ready", {35'd0, ld_wr_ready}, 36'd1);
    tick();
    ld_wr_valid = 1'b0;
    @(negedge clk);
    chk("spur_rf_we", {35'd0, rf_we}, 36'd0);
    chk("spur_err", {35'd0, err}, 36'd1);
    tick();
    @(negedge clk);
    chk("spur_err_sticky", {35'd0, err}, 36'd1);
    chk("spur_pending_kept", {20'd0, pending}, 36'h0_0000_0204);
    tick();

    // Reset mid-operation cancels the in-flight write and forgets pending loads
    alu_wr_valid = 1'b1; alu_wr_dest = 4'd6; alu_wr_data = 32'h6666_6666;
    tick();
    alu_wr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rf_we", {35'd0, rf_we}, 36'd0);
    chk("midrst_err", {35'd0, err}, 36'd0);
    chk("midrst_pending", {20'd0, pending}, 36'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    chk("queue_drained", 36'(exp_q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
